control_sequencer: RTL and testbench

//  Hardwired control unit for the 8-bit ALUSystem datapath (RegFile R1-R4, ARF PC/AR/SP, IR, ALU, Memory).

---
 rtl/control_sequencer_pkg.sv | 99 +++++++++
 rtl/control_sequencer_if.sv | 44 ++++
 rtl/control_sequencer_ctrl_decode.sv | 97 +++++++++
 rtl/control_sequencer.sv | 82 ++++++++
 tb/tb_control_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared opcodes, state encoding and control-word layout for control_sequencer
package control_sequencer_pkg;

    localparam int IR_W   = 16;
    localparam int DATA_W = 8;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 10;
    localparam int RS_MSB = 9;
    localparam int RS_LSB = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_INC = 4'h9;
    localparam logic [3:0] OP_DEC = 4'hA;
    localparam logic [3:0] OP_BRA = 4'hB;
    localparam logic [3:0] OP_BZ  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_CLR  = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_EX0  = 3'd3,
        ST_EX1  = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [1:0] FUN_DEC   = 2'd0;
    localparam logic [1:0] FUN_INC   = 2'd1;
    localparam logic [1:0] FUN_LOAD  = 2'd2;
    localparam logic [1:0] FUN_CLEAR = 2'd3;

    localparam logic [1:0] ADDR_PC = 2'd0;
    localparam logic [1:0] ADDR_AR = 2'd2;

    localparam logic [1:0] MUXA_IMM = 2'd0;
    localparam logic [1:0] MUXA_MEM = 2'd1;
    localparam logic [1:0] MUXA_ALU = 2'd3;
    localparam logic [1:0] MUXB_IMM = 2'd1;

    localparam logic [2:0] ARF_PC_N = 3'b110;
    localparam logic [2:0] ARF_AR_N = 3'b101;

    localparam logic [3:0] ALU_PASS = 4'b0000;

    typedef struct packed {
        logic [1:0] rf_out_a_sel;
        logic [1:0] rf_out_b_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [1:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_fun_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_word_t;

    // Idle: every register enable (active-low) off and memory deselected.
    localparam ctrl_word_t CTRL_IDLE = '{
        rf_out_a_sel: 2'd0, rf_out_b_sel: 2'd0, rf_fun_sel: 2'd0, rf_reg_sel: 4'b1111,
        alu_fun_sel: 4'd0, arf_out_c_sel: 2'd0, arf_out_d_sel: 2'd0, arf_fun_sel: 2'd0,
        arf_reg_sel: 3'b111, ir_lh: 1'b0, ir_enable: 1'b0, ir_fun_sel: 2'd0,
        mem_wr: 1'b0, mem_cs: 1'b1, mux_a_sel: 2'd0, mux_b_sel: 2'd0, mux_c_sel: 1'b0
    };

    function automatic logic [3:0] rf_enable_n(input logic [1:0] idx);
        rf_enable_n = ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD:  alu_code = 4'b0100;
            OP_SUB:  alu_code = 4'b0110;
            OP_AND:  alu_code = 4'b0111;
            OP_OR:   alu_code = 4'b1000;
            OP_XOR:  alu_code = 4'b1001;
            default: alu_code = ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer-to-datapath control bundle
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic            run;
    logic [IR_W-1:0] ir_out;
    logic            z_in;
    logic [1:0]      rf_out_a_sel;
    logic [1:0]      rf_out_b_sel;
    logic [1:0]      rf_fun_sel;
    logic [3:0]      rf_reg_sel;
    logic [3:0]      alu_fun_sel;
    logic [1:0]      arf_out_c_sel;
    logic [1:0]      arf_out_d_sel;
    logic [1:0]      arf_fun_sel;
    logic [2:0]      arf_reg_sel;
    logic            ir_lh;
    logic            ir_enable;
    logic [1:0]      ir_fun_sel;
    logic            mem_wr;
    logic            mem_cs;
    logic [1:0]      mux_a_sel;
    logic [1:0]      mux_b_sel;
    logic            mux_c_sel;
    logic            halted;
    logic [2:0]      state;

    modport master (
        input  run, ir_out, z_in,
        output rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, alu_fun_sel,
               arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
               ir_lh, ir_enable, ir_fun_sel, mem_wr, mem_cs,
               mux_a_sel, mux_b_sel, mux_c_sel, halted, state
    );

    modport slave (
        output run, ir_out, z_in,
        input  rf_out_a_sel, rf_out_b_sel, rf_fun_sel, rf_reg_sel, alu_fun_sel,
               arf_out_c_sel, arf_out_d_sel, arf_fun_sel, arf_reg_sel,
               ir_lh, ir_enable, ir_fun_sel, mem_wr, mem_cs,
               mux_a_sel, mux_b_sel, mux_c_sel, halted, state
    );

endinterface

// File: rtl/control_sequencer_ctrl_decode.sv
// rtl/control_sequencer_ctrl_decode.sv - combinational state + IR to datapath control word
module control_sequencer_ctrl_decode
    import control_sequencer_pkg::*;
(
    input  state_t          state,
    input  logic [IR_W-1:0] ir,
    input  logic            z,
    output ctrl_word_t      word
);

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       unused_imm;

    assign op         = ir[OP_MSB:OP_LSB];
    assign rd         = ir[RD_MSB:RD_LSB];
    assign rs         = ir[RS_MSB:RS_LSB];
    assign unused_imm = ^ir[7:0];

    always_comb begin
        word = CTRL_IDLE;
        case (state)
            ST_CLR: begin
                word.rf_fun_sel  = FUN_CLEAR;
                word.rf_reg_sel  = 4'b0000;
                word.arf_fun_sel = FUN_CLEAR;
                word.arf_reg_sel = ARF_PC_N;
            end
            // Low byte is fetched first from the lower address.
            ST_F0, ST_F1: begin
                word.arf_out_d_sel = ADDR_PC;
                word.mem_cs        = 1'b0;
                word.mem_wr        = 1'b0;
                word.ir_enable     = 1'b1;
                word.ir_fun_sel    = FUN_LOAD;
                word.ir_lh         = (state == ST_F0);
                word.arf_fun_sel   = FUN_INC;
                word.arf_reg_sel   = ARF_PC_N;
            end
            ST_EX0: begin
                case (op)
                    OP_LDI: begin
                        word.mux_a_sel  = MUXA_IMM;
                        word.rf_fun_sel = FUN_LOAD;
                        word.rf_reg_sel = rf_enable_n(rd);
                    end
                    OP_LD, OP_ST: begin
                        word.mux_b_sel   = MUXB_IMM;
                        word.arf_fun_sel = FUN_LOAD;
                        word.arf_reg_sel = ARF_AR_N;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        word.rf_out_a_sel = rd;
                        word.rf_out_b_sel = rs;
                        word.mux_c_sel    = 1'b1;
                        word.mux_a_sel    = MUXA_ALU;
                        word.alu_fun_sel  = alu_code(op);
                        word.rf_fun_sel   = FUN_LOAD;
                        word.rf_reg_sel   = rf_enable_n(rd);
                    end
                    OP_INC, OP_DEC: begin
                        word.rf_fun_sel = (op == OP_INC) ? FUN_INC : FUN_DEC;
                        word.rf_reg_sel = rf_enable_n(rd);
                    end
                    OP_BRA, OP_BZ: begin
                        if (op == OP_BRA || z) begin
                            word.mux_b_sel   = MUXB_IMM;
                            word.arf_fun_sel = FUN_LOAD;
                            word.arf_reg_sel = ARF_PC_N;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EX1: begin
                if (op == OP_LD) begin
                    word.arf_out_d_sel = ADDR_AR;
                    word.mem_cs        = 1'b0;
                    word.mem_wr        = 1'b0;
                    word.mux_a_sel     = MUXA_MEM;
                    word.rf_fun_sel    = FUN_LOAD;
                    word.rf_reg_sel    = rf_enable_n(rd);
                end else if (op == OP_ST) begin
                    word.rf_out_a_sel  = rs;
                    word.mux_c_sel     = 1'b1;
                    word.alu_fun_sel   = ALU_PASS;
                    word.arf_out_d_sel = ADDR_AR;
                    word.mem_cs        = 1'b0;
                    word.mem_wr        = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer for the 8-bit ALUSystem datapath
module control_sequencer
    import control_sequencer_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    control_sequencer_if.master bus
);

    state_t     state;
    state_t     next_state;
    ctrl_word_t dec_word;
    ctrl_word_t word;
    logic [3:0] op;

    assign op = bus.ir_out[OP_MSB:OP_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLR;
        end else if (bus.run) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_CLR:  next_state = ST_F0;
            ST_F0:   next_state = ST_F1;
            ST_F1:   next_state = ST_EX0;
            ST_EX0: begin
                if (op == OP_LD || op == OP_ST) begin
                    next_state = ST_EX1;
                end else if (op == OP_HLT) begin
                    next_state = ST_HALT;
                end else begin
                    next_state = ST_F0;
                end
            end
            ST_EX1:  next_state = ST_F0;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_CLR;
        endcase
    end

    control_sequencer_ctrl_decode u_decode (
        .state (state),
        .ir    (bus.ir_out),
        .z     (bus.z_in),
        .word  (dec_word)
    );

    // rst_n gates the outputs directly so no write can slip out after reset falls.
    always_comb begin
        word = dec_word;
        if (!rst_n || !bus.run) begin
            word = CTRL_IDLE;
        end
    end

    assign bus.rf_out_a_sel  = word.rf_out_a_sel;
    assign bus.rf_out_b_sel  = word.rf_out_b_sel;
    assign bus.rf_fun_sel    = word.rf_fun_sel;
    assign bus.rf_reg_sel    = word.rf_reg_sel;
    assign bus.alu_fun_sel   = word.alu_fun_sel;
    assign bus.arf_out_c_sel = word.arf_out_c_sel;
    assign bus.arf_out_d_sel = word.arf_out_d_sel;
    assign bus.arf_fun_sel   = word.arf_fun_sel;
    assign bus.arf_reg_sel   = word.arf_reg_sel;
    assign bus.ir_lh         = word.ir_lh;
    assign bus.ir_enable     = word.ir_enable;
    assign bus.ir_fun_sel    = word.ir_fun_sel;
    assign bus.mem_wr        = word.mem_wr;
    assign bus.mem_cs        = word.mem_cs;
    assign bus.mux_a_sel     = word.mux_a_sel;
    assign bus.mux_b_sel     = word.mux_b_sel;
    assign bus.mux_c_sel     = word.mux_c_sel;
    assign bus.halted        = rst_n && (state == ST_HALT);
    assign bus.state         = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - datapath model plus instruction-level scoreboard for control_sequencer
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam int NUM_TESTS = 10;
    localparam int BUDGET    = 1500;
    localparam logic [33:0] IDLE_CTL = {2'd0, 2'd0, 2'd0, 4'hF, 4'h0, 2'd0, 2'd0, 2'd0,
                                        3'b111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};

    typedef struct packed {
        logic [31:0] regs;
        logic [7:0]  pc;
        logic [3:0]  cyc;
        logic        halt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if bus();
    control_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    logic [7:0]  prog [256];
    logic [7:0]  mem [256];
    logic [7:0]  rf [4];
    logic [7:0]  pc, ar, sp;
    logic [15:0] ir;
    logic        zf;
    logic [7:0]  dp_addr, dp_mem, dp_a, dp_b, dp_alu, dp_rf_in, dp_arf_in;

    logic [7:0]  ref_rf [4];
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_pc;
    logic        ref_z;

    assign bus.ir_out = ir;
    assign bus.z_in   = zf;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [33:0] ctl();
        return {bus.rf_out_a_sel, bus.rf_out_b_sel, bus.rf_fun_sel, bus.rf_reg_sel, bus.alu_fun_sel,
                bus.arf_out_c_sel, bus.arf_out_d_sel, bus.arf_fun_sel, bus.arf_reg_sel, bus.ir_lh,
                bus.ir_enable, bus.ir_fun_sel, bus.mem_wr, bus.mem_cs, bus.mux_a_sel, bus.mux_b_sel,
                bus.mux_c_sel};
    endfunction

    function automatic logic [7:0] upd(input logic [7:0] cur, input logic [1:0] fun, input logic [7:0] din);
        case (fun)
            2'd0:    return cur - 8'd1;
            2'd1:    return cur + 8'd1;
            2'd2:    return din;
            default: return 8'd0;
        endcase
    endfunction

    // Datapath stand-in: reacts only to the control signals the sequencer drives.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'($urandom);
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            pc <= 8'($urandom);
            ar <= 8'($urandom);
            sp <= 8'hFF;
            ir <= 16'($urandom);
            zf <= 1'b0;
        end else begin
            case (bus.arf_out_d_sel)
                2'd2:    dp_addr = ar;
                2'd3:    dp_addr = sp;
                default: dp_addr = pc;
            endcase
            dp_mem = mem[dp_addr];
            dp_a   = bus.mux_c_sel ? rf[bus.rf_out_a_sel] : pc;
            dp_b   = rf[bus.rf_out_b_sel];
            case (bus.alu_fun_sel)
                4'b0100: dp_alu = dp_a + dp_b;
                4'b0110: dp_alu = dp_a - dp_b;
                4'b0111: dp_alu = dp_a & dp_b;
                4'b1000: dp_alu = dp_a | dp_b;
                4'b1001: dp_alu = dp_a ^ dp_b;
                default: dp_alu = dp_a;
            endcase
            if (bus.alu_fun_sel inside {4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b1001})
                zf <= (dp_alu == 8'd0);
            case (bus.mux_a_sel)
                2'd0:    dp_rf_in = ir[7:0];
                2'd1:    dp_rf_in = dp_mem;
                2'd2:    dp_rf_in = pc;
                default: dp_rf_in = dp_alu;
            endcase
            case (bus.mux_b_sel)
                2'd1:    dp_arf_in = ir[7:0];
                2'd2:    dp_arf_in = dp_mem;
                2'd3:    dp_arf_in = dp_alu;
                default: dp_arf_in = 8'd0;
            endcase
            for (int i = 0; i < 4; i++)
                if (!bus.rf_reg_sel[i]) rf[i] <= upd(rf[i], bus.rf_fun_sel, dp_rf_in);
            if (!bus.arf_reg_sel[0]) pc <= upd(pc, bus.arf_fun_sel, dp_arf_in);
            if (!bus.arf_reg_sel[1]) ar <= upd(ar, bus.arf_fun_sel, dp_arf_in);
            if (!bus.arf_reg_sel[2]) sp <= upd(sp, bus.arf_fun_sel, dp_arf_in);
            if (bus.ir_enable && bus.ir_fun_sel == 2'd2) begin
                if (bus.ir_lh) ir[7:0] <= dp_mem;
                else           ir[15:8] <= dp_mem;
            end
            if (!bus.mem_cs && bus.mem_wr) mem[dp_addr] <= dp_alu;
        end
    end

    // Instruction-set reference: executes whole instructions and queues the expected outcome.
    task automatic run_ref(input int max_instr);
        logic [7:0] lo, hi, r;
        logic [3:0] op;
        logic [1:0] rd, rs;
        exp_t e;
        for (int i = 0; i < 4; i++) ref_rf[i] = 8'd0;
        ref_pc = 8'd0;
        ref_z  = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            lo = ref_mem[ref_pc];
            hi = ref_mem[8'(ref_pc + 8'd1)];
            ref_pc = ref_pc + 8'd2;
            op = hi[7:4]; rd = hi[3:2]; rs = hi[1:0];
            e.cyc = 4'd3;
            e.halt = 1'b0;
            case (op)
                4'h1: ref_rf[rd] = lo;
                4'h2: begin ref_rf[rd] = ref_mem[lo]; e.cyc = 4'd4; end
                4'h3: begin ref_mem[lo] = ref_rf[rs]; e.cyc = 4'd4; end
                4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                    case (op)
                        4'h4:    r = ref_rf[rd] + ref_rf[rs];
                        4'h5:    r = ref_rf[rd] - ref_rf[rs];
                        4'h6:    r = ref_rf[rd] & ref_rf[rs];
                        4'h7:    r = ref_rf[rd] | ref_rf[rs];
                        default: r = ref_rf[rd] ^ ref_rf[rs];
                    endcase
                    ref_rf[rd] = r;
                    ref_z = (r == 8'd0);
                end
                4'h9: ref_rf[rd] = ref_rf[rd] + 8'd1;
                4'hA: ref_rf[rd] = ref_rf[rd] - 8'd1;
                4'hB: ref_pc = lo;
                4'hC: if (ref_z) ref_pc = lo;
                4'hF: e.halt = 1'b1;
                default: ;
            endcase
            e.regs = {ref_rf[3], ref_rf[2], ref_rf[1], ref_rf[0]};
            e.pc   = ref_pc;
            exp_q.push_back(e);
            if (e.halt) break;
        end
    endtask

    int         cnt = 0;
    bit         halt_seen = 0;
    bit         prev_valid = 0;
    logic       prev_run;
    logic [2:0] prev_state;

    task automatic cmp_instr();
        exp_t e;
        chk(exp_q.size() != 0, "queue_underrun", 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({rf[3], rf[2], rf[1], rf[0]} == e.regs, "regs", {rf[3], rf[2], rf[1], rf[0]}, e.regs);
        chk(pc == e.pc, "pc", pc, e.pc);
        chk(cnt == int'(e.cyc), "cycles", cnt, e.cyc);
        chk(bus.halted == e.halt, "halted", bus.halted, e.halt);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0;
            halt_seen = 0;
            prev_valid = 0;
        end else begin
            if (!bus.run) chk(ctl() == IDLE_CTL, "run_low_idle", ctl(), IDLE_CTL);
            if (prev_valid && !prev_run) chk(bus.state == prev_state, "freeze", bus.state, prev_state);
            if (bus.ir_enable) chk(bus.ir_fun_sel == 2'd2, "ir_fun_sel", bus.ir_fun_sel, 2);
            if (!bus.mem_cs && bus.mem_wr)
                chk(bus.state == ST_EX1 && bus.ir_out[15:12] == 4'h3, "write_only_st_ex1",
                    {bus.state, bus.ir_out[15:12]}, {ST_EX1, 4'h3});
            if (bus.state == ST_EX0 || bus.state == ST_EX1)
                chk(int'(bus.rf_reg_sel != 4'hF) + int'(bus.arf_reg_sel != 3'h7)
                    + int'(!bus.mem_cs && bus.mem_wr) <= 1, "single_write", bus.rf_reg_sel, 4'hF);
            chk(bus.halted == (bus.state == ST_HALT), "halted_flag", bus.halted, bus.state);
            if (bus.state == ST_HALT && !halt_seen) begin
                halt_seen = 1;
                cmp_instr();
            end else if (bus.state == ST_F0 && bus.run && cnt > 0) begin
                cmp_instr();
                cnt = 0;
            end
            if (bus.run && bus.state inside {ST_F0, ST_F1, ST_EX0, ST_EX1}) cnt++;
            prev_run = bus.run;
            prev_state = bus.state;
            prev_valid = 1;
        end
    end

    initial begin
        bus.run = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.run = ($urandom_range(0, 4) != 0);
        end
    end

    task automatic load_prog(input int t);
        logic [7:0] directed [0:11] = '{8'h05, 8'h10, 8'h3C, 8'h10, 8'h40, 8'h24,
                                         8'h41, 8'h30, 8'h00, 8'h50, 8'h20, 8'hC0};
        logic [7:0] tail [0:9] = '{8'h01, 8'h10, 8'h02, 8'h14, 8'h00, 8'h51,
                                   8'h30, 8'hC0, 8'h00, 8'hF0};
        for (int i = 0; i < 256; i++) prog[i] = (t == 0) ? 8'h00 : 8'($urandom);
        if (t == 0) begin
            for (int i = 0; i < 12; i++) prog[i] = directed[i];
            for (int i = 0; i < 10; i++) prog[8'h20 + i] = tail[i];
            prog[8'h40] = 8'hA5;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = prog[i];
    endtask

    initial begin
        int cyc;
        int bad;
        load_prog(0);
        run_ref(20);
        repeat (3) @(negedge clk);
        chk(ctl() == IDLE_CTL, "reset_idle", ctl(), IDLE_CTL);
        chk(bus.halted == 1'b0, "reset_halted", bus.halted, 0);
        for (int t = 0; t < NUM_TESTS; t++) begin
            @(negedge clk);
            #1 rst_n = 1'b1;
            #1 chk(bus.state == ST_CLR, "start_clr", bus.state, ST_CLR);
            cyc = 0;
            while (exp_q.size() != 0 && cyc < BUDGET) begin
                @(negedge clk);
                #1 cyc++;
            end
            chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
            rst_n = 1'b0;
            #1 chk(ctl() == IDLE_CTL, "async_reset_idle", ctl(), IDLE_CTL);
            chk(bus.halted == 1'b0, "async_reset_halted", bus.halted, 0);
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk(bad == 0, "memory", bad, 0);
            exp_q.delete();
            if (t + 1 < NUM_TESTS) begin
                load_prog(t + 1);
                run_ref(30);
            end
            repeat (2) @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
